// File: rtl/adder_result_accum_if.sv
// Beat/result handshake bundle between the adder output stage, the batch
// accumulator and its consumer. The slave view is the accumulator's side.
interface adder_result_accum_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 40,
  parameter int CW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CW-1:0]    out_carries;
  logic             out_ovf;

  modport master (
    output in_valid, in_s, in_cout, out_ready,
    input  in_ready, out_valid, out_sum, out_carries, out_ovf
  );

  modport slave (
    input  in_valid, in_s, in_cout, out_ready,
    output in_ready, out_valid, out_sum, out_carries, out_ovf
  );
endinterface

// File: rtl/adder_result_accum.sv
// Accumulates COUNT {cout, s} beats from the adder into a wide sum, counts
// carry-outs and flags wrap, then holds the batch result on a valid/ready port.
module adder_result_accum #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4,
  parameter int EXT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_result_accum_if.slave  bus
);
  localparam int ACC_W = WIDTH + EXT;
  localparam int CW    = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_carries;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_accept;
  logic [ACC_W-1:0] w_beat;
  logic [ACC_W:0]   w_sum;
  logic             w_last;

  // Readiness is a pure state decode, so acceptance never looks at out_ready.
  assign w_accept = bus.in_valid && r_in_ready;
  assign w_beat   = ACC_W'({bus.in_cout, bus.in_s});
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_beat};
  assign w_last   = (r_cnt == CW'(COUNT - 1));

  // NOTE: every register here is updated with non-blocking assignments so all
  // of them see pre-edge values; blocking here would chain updates in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_carries   <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_sum[ACC_W-1:0];
            r_ovf     <= r_ovf | w_sum[ACC_W];
            r_carries <= r_carries + CW'(bus.in_cout);
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
              r_state     <= HOLD;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_carries   <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_acc       <= '0;
          r_cnt       <= '0;
          r_carries   <= '0;
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_sum     = r_acc;
  assign bus.out_carries = r_carries;
  assign bus.out_ovf     = r_ovf;
endmodule

// File: tb/tb_adder_result_accum.sv
// Bench for adder_result_accum: default build plus a narrow WIDTH=8/EXT=1 build
// that exercises accumulator wrap, checked against an arithmetic batch model.
module tb_adder_result_accum;
  localparam int WIDTH   = 32;
  localparam int COUNT   = 4;
  localparam int EXT     = 8;
  localparam int ACC_W   = WIDTH + EXT;
  localparam int CW      = $clog2(COUNT + 1);
  localparam int S_WIDTH = 8;
  localparam int S_EXT   = 1;
  localparam int S_ACC_W = S_WIDTH + S_EXT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_result_accum_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CW(CW)) ifa ();
  adder_result_accum_if #(.WIDTH(S_WIDTH), .ACC_W(S_ACC_W), .CW(CW)) ifb ();

  adder_result_accum #(.WIDTH(WIDTH), .COUNT(COUNT), .EXT(EXT)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  adder_result_accum #(.WIDTH(S_WIDTH), .COUNT(COUNT), .EXT(S_EXT)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q_s[$];
  bit               q_c[$];
  int               q_gap[$];

  longint unsigned exp_sum;
  int              exp_c;
  bit              exp_ovf;

  // Batch model: plain sum of {cout,s} values; wrap means total reached 2^ACC_W.
  task automatic build_exp(input int width, input int acc_w);
    longint unsigned total = 0;
    exp_c = 0;
    foreach (q_s[i]) begin
      total += (64'(q_c[i]) << width) + 64'(q_s[i]);
      exp_c += int'(q_c[i]);
    end
    exp_sum = total % (64'd1 << acc_w);
    exp_ovf = (total >= (64'd1 << acc_w));
  endtask

  // Drives the queued beats into dut_a, waiting for in_ready before each one.
  task automatic drive_a(output int early);
    early = 0;
    for (int i = 0; i < q_s.size(); i++) begin
      ifa.in_valid = 1'b0;
      for (int g = 0; g < q_gap[i]; g++) begin
        @(negedge clk);
        if (i > 0 && ifa.out_valid === 1'b1) early++;
      end
      ifa.in_s     = q_s[i];
      ifa.in_cout  = q_c[i];
      ifa.in_valid = 1'b1;
      for (int w = 0; ifa.in_ready !== 1'b1; w++) begin
        if (w >= 20) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: in_ready=%b required 1", ifa.in_ready);
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
      if (i < q_s.size() - 1 && ifa.out_valid === 1'b1) early++;
    end
    ifa.in_valid = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] s0, s1, s2, s3, input bit c, input int max_gap);
    q_s = '{s0, s1, s2, s3};
    q_c = '{c, c, c, c};
    q_gap.delete();
    for (int i = 0; i < 4; i++) q_gap.push_back(max_gap == 0 ? 0 : int'($urandom_range(max_gap, 0)));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.out_sum !== '0) begin errors++; $display("FAIL rst_out_sum: got %h expected 0", ifa.out_sum); end
    checks++; if (ifa.out_carries !== '0) begin errors++; $display("FAIL rst_carries: got %0d expected 0", ifa.out_carries); end
    checks++; if (ifa.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", ifa.out_ovf); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", ifa.in_ready); end
    checks++; if (ifb.in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_in_ready: got %b expected 1", ifb.in_ready); end
  endtask

  // Expects dut_a to be presenting the result of the queued batch right now.
  task automatic test_result(input string name, input int early);
    build_exp(WIDTH, ACC_W);
    checks++; if (early != 0) begin errors++; $display("FAIL %s_early_valid: got %0d cycles expected 0", name, early); end
    checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL %s_out_valid: got %b expected 1", name, ifa.out_valid); end
    checks++; if (ifa.out_sum !== exp_sum[ACC_W-1:0]) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, ifa.out_sum, exp_sum[ACC_W-1:0]); end
    checks++; if (ifa.out_carries !== CW'(exp_c)) begin errors++; $display("FAIL %s_carries: got %0d expected %0d", name, ifa.out_carries, exp_c); end
    checks++; if (ifa.out_ovf !== exp_ovf) begin errors++; $display("FAIL %s_ovf: got %b expected %b", name, ifa.out_ovf, exp_ovf); end
    checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL %s_hold_in_ready: got %b expected 0", name, ifa.in_ready); end
  endtask

  task automatic test_basic();
    int early;
    ifa.out_ready = 1'b1;
    load(1, 2, 3, 4, 1'b0, 0);
    drive_a(early);
    test_result("basic", early);
    @(negedge clk);
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL basic_release_ready: got %b expected 1", ifa.in_ready); end
  endtask

  task automatic test_carries();
    int early;
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    drive_a(early);
    test_result("carries", early);
    @(negedge clk);
  endtask

  task automatic test_hold_stall();
    int early;
    ifa.out_ready = 1'b0;
    load($urandom, $urandom, $urandom, $urandom, 1'b0, 1);
    drive_a(early);
    test_result("stall", early);
    ifa.in_valid = 1'b1;
    ifa.in_s     = 9;
    ifa.in_cout  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1", k, ifa.out_valid); end
      checks++; if (ifa.out_sum !== exp_sum[ACC_W-1:0]) begin errors++; $display("FAIL stall_sum_%0d: got %h expected %h", k, ifa.out_sum, exp_sum[ACC_W-1:0]); end
      checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b expected 0", k, ifa.in_ready); end
    end
    ifa.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", ifa.in_ready); end
    load(9, 9, 9, 9, 1'b0, 0);
    drive_a(early);
    test_result("stall_next", early);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int early;
    q_s = '{7, 7};
    q_c = '{1'b0, 1'b0};
    q_gap = '{0, 0};
    drive_a(early);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ifa.out_sum !== '0) begin errors++; $display("FAIL midrst_sum: got %h expected 0", ifa.out_sum); end
    checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", ifa.out_valid); end
    checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ifa.in_ready); end
    load(5, 5, 5, 5, 1'b0, 0);
    drive_a(early);
    test_result("midrst", early);
    @(negedge clk);
  endtask

  task automatic test_idle_gaps();
    int early;
    load(3, 32'h10, 1, 2, 1'b0, 3);
    drive_a(early);
    test_result("gaps", early);
    for (int n = 0; n < 12; n++) begin
      q_s.delete(); q_c.delete(); q_gap.delete();
      for (int i = 0; i < COUNT; i++) begin
        q_s.push_back($urandom);
        q_c.push_back(1'($urandom));
        q_gap.push_back(int'($urandom_range(3, 0)));
      end
      drive_a(early);
      test_result($sformatf("rand%0d", n), early);
    end
    @(negedge clk);
  endtask

  task automatic test_small_ovf();
    ifb.out_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      q_s.delete(); q_c.delete();
      for (int i = 0; i < COUNT; i++) begin
        q_s.push_back(pass == 0 ? 32'hFF : 32'h1);
        q_c.push_back(pass == 0);
        ifb.in_s     = (pass == 0) ? 8'hFF : 8'h01;
        ifb.in_cout  = (pass == 0);
        ifb.in_valid = 1'b1;
        @(negedge clk);
      end
      ifb.in_valid = 1'b0;
      build_exp(S_WIDTH, S_ACC_W);
      checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL small%0d_valid: got %b expected 1", pass, ifb.out_valid); end
      checks++; if (ifb.out_sum !== exp_sum[S_ACC_W-1:0]) begin errors++; $display("FAIL small%0d_sum: got %h expected %h", pass, ifb.out_sum, exp_sum[S_ACC_W-1:0]); end
      checks++; if (ifb.out_carries !== CW'(exp_c)) begin errors++; $display("FAIL small%0d_carries: got %0d expected %0d", pass, ifb.out_carries, exp_c); end
      checks++; if (ifb.out_ovf !== exp_ovf) begin errors++; $display("FAIL small%0d_ovf: got %b expected %b", pass, ifb.out_ovf, exp_ovf); end
      @(negedge clk);
      checks++; if (ifb.out_valid !== 1'b0) begin errors++; $display("FAIL small%0d_release: got %b expected 0", pass, ifb.out_valid); end
    end
  endtask

  initial begin
    rst           = 1'b1;
    ifa.in_valid  = 1'b0;
    ifa.in_s      = '0;
    ifa.in_cout   = 1'b0;
    ifa.out_ready = 1'b0;
    ifb.in_valid  = 1'b0;
    ifb.in_s      = '0;
    ifb.in_cout   = 1'b0;
    ifb.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_carries();
    test_hold_stall();
    test_reset_mid();
    test_idle_gaps();
    test_small_ovf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
